// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter_if
// Brief    : Two requester operand channels and one result channel for
//            adder_arbiter.
// Revision : 1.0
// ============================================================================
interface adder_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_op1;
    logic [WIDTH-1:0] req0_op2;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_op1;
    logic [WIDTH-1:0] req1_op2;
    logic             req1_ready;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res;
    logic             res_id;
    logic             res_carry;
    logic             res_ovf;

    // Requesters and result consumer.
    modport master (
        output req0_valid, req0_op1, req0_op2,
        input  req0_ready,
        output req1_valid, req1_op1, req1_op2,
        input  req1_ready,
        output res_ready,
        input  res_valid, res, res_id, res_carry, res_ovf
    );

    // The arbitrated adder.
    modport slave (
        input  req0_valid, req0_op1, req0_op2,
        output req0_ready,
        input  req1_valid, req1_op1, req1_op2,
        output req1_ready,
        input  res_ready,
        output res_valid, res, res_id, res_carry, res_ovf
    );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin arbiter sharing one registered adder between two
//            valid/ready requesters.
// Revision : 1.0
// ============================================================================
module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    adder_arbiter_if.slave   bus
);

    localparam int c_msb = WIDTH - 1;

    logic             r_prio;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_res_id;
    logic             r_res_carry;
    logic             r_res_ovf;

    logic             w_free;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_grant;
    logic             w_sel;
    logic [WIDTH-1:0] w_op1;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    // Grants depend only on valids, output-stage state and prio, never on operands.
    assign w_free   = !r_res_valid || bus.res_ready;
    assign w_grant0 = !rst && w_free && bus.req0_valid && (!bus.req1_valid || !r_prio);
    assign w_grant1 = !rst && w_free && bus.req1_valid && (!bus.req0_valid ||  r_prio);
    assign w_grant  = w_grant0 || w_grant1;
    assign w_sel    = w_grant1;

    // Single shared adder fed by the granted requester's operands.
    assign w_op1 = w_sel ? bus.req1_op1 : bus.req0_op1;
    assign w_op2 = w_sel ? bus.req1_op2 : bus.req0_op2;
    assign w_sum = {1'b0, w_op1} + {1'b0, w_op2};
    assign w_ovf = (w_op1[c_msb] == w_op2[c_msb]) && (w_sum[c_msb] != w_op1[c_msb]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
            r_res_id    <= 1'b0;
            r_res_carry <= 1'b0;
            r_res_ovf   <= 1'b0;
        end else if (w_grant) begin
            r_prio      <= !w_sel;
            r_res_valid <= 1'b1;
            r_res       <= w_sum[c_msb:0];
            r_res_id    <= w_sel;
            r_res_carry <= w_sum[WIDTH];
            r_res_ovf   <= w_ovf;
        end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.res_valid  = r_res_valid;
    assign bus.res        = r_res;
    assign bus.res_id     = r_res_id;
    assign bus.res_carry  = r_res_carry;
    assign bus.res_ovf    = r_res_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_arbiter
// Brief    : Scoreboard testbench for adder_arbiter.
// Revision : 1.0
// ============================================================================
module tb_adder_arbiter;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         id;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_arbiter_if #(.WIDTH(W)) bus ();

    adder_arbiter #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic m_valid = 1'b0;
    logic m_prio  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic id);
        exp_t e;
        logic [W:0] s;
        s       = {1'b0, a} + {1'b0, b};
        e.res   = s[W-1:0];
        e.id    = id;
        e.carry = s[W];
        e.ovf   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle for the coming edge.
    always @(negedge clk) begin : mon
        logic g0, g1, free;
        exp_t h;
        if (rst) begin
            check("ready_in_rst", {bus.req0_ready, bus.req1_ready}, 0);
            q.delete();
            m_valid = 1'b0;
            m_prio  = 1'b0;
        end else begin
            check("res_valid", bus.res_valid, m_valid);
            if (m_valid) begin
                check("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    h = q[0];
                    check("res",       bus.res,       h.res);
                    check("res_id",    bus.res_id,    h.id);
                    check("res_carry", bus.res_carry, h.carry);
                    check("res_ovf",   bus.res_ovf,   h.ovf);
                    if (bus.res_ready) void'(q.pop_front());
                end
            end
            free = !m_valid || bus.res_ready;
            g0 = free && bus.req0_valid && (!bus.req1_valid || !m_prio);
            g1 = free && bus.req1_valid && (!bus.req0_valid ||  m_prio);
            check("req0_ready", bus.req0_ready, g0);
            check("req1_ready", bus.req1_ready, g1);
            if (g0) q.push_back(model_add(bus.req0_op1, bus.req0_op2, 1'b0));
            if (g1) q.push_back(model_add(bus.req1_op1, bus.req1_op2, 1'b1));
            if (g0 || g1) begin
                m_valid = 1'b1;
                m_prio  = g0;
            end else if (bus.res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        logic done;
        done = 1'b0;
        if (id) begin bus.req1_valid = 1'b1; bus.req1_op1 = a; bus.req1_op2 = b; end
        else    begin bus.req0_valid = 1'b1; bus.req0_op1 = a; bus.req0_op2 = b; end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                tick();
                done = 1'b1;
            end
        end
        check("send_accepted", done, 1);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic drain();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        for (int i = 0; i < 50 && (q.size() != 0 || bus.res_valid); i++) tick();
        check("drain", q.size(), 0);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_op1 = '0; bus.req0_op2 = '0;
        bus.req1_valid = 1'b0; bus.req1_op1 = '0; bus.req1_op2 = '0;
        bus.res_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.res_valid, 0);
        check("rst_res",   bus.res,       0);
        check("rst_id",    bus.res_id,    0);
        check("rst_carry", bus.res_carry, 0);
        check("rst_ovf",   bus.res_ovf,   0);
        tick();
        rst = 1'b0;
        bus.res_ready = 1'b1;

        // Single and wrap cases with literal expectations
        send(1'b0, 32'd1, 32'd2);
        @(negedge clk);
        check("single_res", {bus.res_valid, bus.res_id, bus.res_carry, bus.res_ovf, bus.res}, {4'b1000, 32'd3});
        tick();
        send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        check("wrap_res", {bus.res_valid, bus.res_id, bus.res_carry, bus.res_ovf, bus.res}, {4'b1110, 32'h0});
        tick();
        send(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        check("ovf_res", {bus.res_valid, bus.res_carry, bus.res_ovf, bus.res}, {3'b101, 32'h8000_0000});
        tick();
        drain();

        // Contention straight after reset: ids alternate, one result per cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.req0_op1 = $urandom; bus.req0_op2 = $urandom;
            bus.req1_op1 = $urandom; bus.req1_op2 = $urandom;
            tick();
            @(negedge clk);
            check("alt_valid", bus.res_valid, 1);
            check("alt_id",    bus.res_id,    k[0]);
        end

        // Backpressure holds the result and blocks both requesters
        tick();
        bus.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check("bp_ready", {bus.req0_ready, bus.req1_ready}, 0);
            if (q.size() != 0) check("bp_hold", {bus.res_id, bus.res}, {q[0].id, q[0].res});
        end
        tick();
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", bus.req0_ready ^ bus.req1_ready, 1);
        tick();
        drain();

        // Reset mid-operation discards the pending result and clears prio
        bus.res_ready = 1'b0;
        send(1'b0, 32'd5, 32'd6);
        @(negedge clk);
        check("mid_pending", bus.res_valid, 1);
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_valid_cleared", bus.res_valid, 0);
        check("mid_first_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
        tick();
        drain();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            bus.req0_valid = ($urandom_range(0, 9) < 7);
            bus.req1_valid = ($urandom_range(0, 9) < 7);
            bus.res_ready  = ($urandom_range(0, 3) != 0);
            bus.req0_op1   = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            bus.req0_op2   = $urandom;
            bus.req1_op1   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            bus.req1_op2   = $urandom;
            tick();
        end
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
